// File: rtl/serial_arb_pkg.sv
// ---------------------------------------------------------------------------
// serial_arb_pkg
// Shared types and constants for the Serial port round-robin arbiter.
//   arb_state_t       : arbiter FSM state encoding (IDLE / BUSY)
//   SERIAL_*_OFFSET   : register map of the Serial peripheral
//   ARB_MAX_REQ       : largest supported requester count
//   ARB_ABORT_RDATA   : read data returned on a timed-out transaction
//   rr_next_idx()     : modulo-NUM_REQ index advance used by the picker
// ---------------------------------------------------------------------------
package serial_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam logic [31:0] SERIAL_DIV_OFFSET = 32'h0000_0000;
    localparam logic [31:0] SERIAL_DAT_OFFSET = 32'h0000_0004;

    localparam int          ARB_MAX_REQ     = 4;
    localparam int          ARB_IDX_W       = 2;
    // One extra bit so that base + offset cannot overflow before the wrap.
    localparam int          ARB_CNT_W       = ARB_IDX_W + 1;

    localparam logic [31:0] ARB_ABORT_RDATA = 32'hFFFF_FFFF;

    // (base + offset) mod num, valid while base < num and offset <= num,
    // so a single conditional subtract is enough for the wrap.
    function automatic logic [ARB_IDX_W-1:0] rr_next_idx(
        input logic [ARB_IDX_W-1:0] base,
        input logic [ARB_CNT_W-1:0] offset,
        input logic [ARB_CNT_W-1:0] num
    );
        logic [ARB_CNT_W-1:0] sum;
        sum = {1'b0, base} + offset;
        if (sum >= num) begin
            sum = sum - num;
        end else begin
            sum = sum;
        end
        return sum[ARB_IDX_W-1:0];
    endfunction

endpackage : serial_arb_pkg

// File: rtl/serial_bus_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches upward from i_last+1, wrapping
// modulo NUM_REQ, and reports the first requester whose bit is set.
//   i_req   [NUM_REQ]   : request vector
//   i_last  [2]         : index granted most recently
//   o_found             : at least one request is pending
//   o_idx   [2]         : winning requester index (0 when o_found is low)
// ---------------------------------------------------------------------------
module rr_pick
    import serial_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [ARB_IDX_W-1:0] i_last,
    output logic                 o_found,
    output logic [ARB_IDX_W-1:0] o_idx
);

    logic [ARB_MAX_REQ-1:0] w_req_ext;

    // Widen the request vector so it can be indexed with a full-width index.
    always_comb begin
        w_req_ext              = '0;
        w_req_ext[NUM_REQ-1:0] = i_req;
    end

    // Walk offsets from farthest to nearest; the nearest hit is written last
    // and therefore wins, which gives the rotating priority.
    always_comb begin
        logic [ARB_IDX_W-1:0] w_cand;
        o_found = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_cand = rr_next_idx(i_last, ARB_CNT_W'(k), ARB_CNT_W'(NUM_REQ));
            if (w_req_ext[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end else begin
                o_found = o_found;
            end
        end
    end

endmodule : rr_pick

// File: rtl/serial_bus_arbiter.sv
// ---------------------------------------------------------------------------
// serial_bus_arbiter
// Round-robin arbiter sharing one Serial peripheral port between up to four
// native-bus requesters. A grant is held for a whole transaction, so a
// stalled TX write is never interleaved with another requester's access.
//
// Parameters
//   NUM_REQ        : requester count, 2..4
//   TIMEOUT_CYCLES : abort limit in BUSY cycles (timeout build only)
// Build option
//   SERIAL_ARB_TIMEOUT_EN : when defined, a BUSY transaction that sees no
//                           m_ready for TIMEOUT_CYCLES cycles is aborted with
//                           req_ready + ARB_ABORT_RDATA + timeout_err pulse.
// Ports
//   clk, resetn                       : clock, async active-low reset
//   req_valid/req_ready [NUM_REQ]     : per-requester handshake
//   req_wstrb/req_addr/req_wdata      : packed per-requester request fields
//   req_rdata [32]                    : shared read data, qualified by ready
//   m_valid/m_wstrb/m_addr/m_wdata    : port into Serial
//   m_ready/m_rdata                   : Serial response
//   timeout_err                       : one-cycle abort pulse
// ---------------------------------------------------------------------------
module serial_bus_arbiter
    import serial_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [4*NUM_REQ-1:0]    req_wstrb,
    input  logic [32*NUM_REQ-1:0]   req_addr,
    input  logic [32*NUM_REQ-1:0]   req_wdata,
    output logic [31:0]             req_rdata,
    output logic                    m_valid,
    output logic [3:0]              m_wstrb,
    output logic [31:0]             m_addr,
    output logic [31:0]             m_wdata,
    input  logic                    m_ready,
    input  logic [31:0]             m_rdata,
    output logic                    timeout_err
);

    if (NUM_REQ < 2 || NUM_REQ > ARB_MAX_REQ || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("serial_bus_arbiter: NUM_REQ must be 2..4 and TIMEOUT_CYCLES >= 1");
    end

    arb_state_t             r_state;
    arb_state_t             w_next_state;
    logic [ARB_IDX_W-1:0]   r_grant;
    logic [ARB_IDX_W-1:0]   w_next_grant;
    logic [ARB_IDX_W-1:0]   r_last_grant;
    logic [ARB_IDX_W-1:0]   w_next_last;
    logic                   w_found;
    logic [ARB_IDX_W-1:0]   w_pick;
    logic                   w_busy;
    logic                   w_grant_valid;
    logic                   w_to_hit;
    logic                   w_abort;
    logic [NUM_REQ-1:0]     w_ready;

    logic [ARB_MAX_REQ-1:0] w_valid_ext;
    logic [3:0]             w_wstrb_a [ARB_MAX_REQ];
    logic [31:0]            w_addr_a  [ARB_MAX_REQ];
    logic [31:0]            w_wdata_a [ARB_MAX_REQ];

    // Unpack requester lanes; absent lanes read as idle so a full-width
    // grant index can address them safely.
    for (genvar gi = 0; gi < ARB_MAX_REQ; gi++) begin : g_lane
        if (gi < NUM_REQ) begin : g_real
            assign w_valid_ext[gi] = req_valid[gi];
            assign w_wstrb_a[gi]   = req_wstrb[4*gi +: 4];
            assign w_addr_a[gi]    = req_addr[32*gi +: 32];
            assign w_wdata_a[gi]   = req_wdata[32*gi +: 32];
        end else begin : g_absent
            assign w_valid_ext[gi] = 1'b0;
            assign w_wstrb_a[gi]   = 4'h0;
            assign w_addr_a[gi]    = 32'h0000_0000;
            assign w_wdata_a[gi]   = 32'h0000_0000;
        end
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .i_req   (req_valid),
        .i_last  (r_last_grant),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    assign w_busy        = (r_state == BUSY);
    assign w_grant_valid = w_valid_ext[r_grant];

`ifdef SERIAL_ARB_TIMEOUT_EN
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] r_to_cnt;

    // BUSY-cycle counter; held at zero in IDLE so every BUSY entry starts
    // from zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_to_cnt <= 32'h0000_0000;
        end else if (!w_busy) begin
            r_to_cnt <= 32'h0000_0000;
        end else if (!m_ready) begin
            r_to_cnt <= r_to_cnt + 32'h0000_0001;
        end else begin
            r_to_cnt <= r_to_cnt;
        end
    end

    // m_valid is dropped on the limit cycle from the count alone, keeping
    // m_valid independent of m_ready (no valid->ready->valid loop).
    assign w_to_hit = w_busy && (r_to_cnt == TO_LAST);
    assign w_abort  = w_to_hit && !m_ready;
`else
    assign w_to_hit = 1'b0;
    assign w_abort  = 1'b0;
`endif

    // State, grant and last-grant registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_last_grant <= ARB_IDX_W'(NUM_REQ - 1);
        end else begin
            r_state      <= w_next_state;
            r_grant      <= w_next_grant;
            r_last_grant <= w_next_last;
        end
    end

    // Next-state logic: arbitrate in IDLE, hold the grant in BUSY until the
    // transaction completes, aborts, or the requester withdraws.
    always_comb begin
        w_next_state = r_state;
        w_next_grant = r_grant;
        w_next_last  = r_last_grant;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_next_state = BUSY;
                    w_next_grant = w_pick;
                    w_next_last  = w_pick;
                end else begin
                    w_next_state = IDLE;
                end
            end
            BUSY: begin
                if (m_ready || w_abort || !w_grant_valid) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = BUSY;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Per-requester completion strobe: only the granted lane can see ready.
    always_comb begin
        w_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_busy && (r_grant == ARB_IDX_W'(i)) && (m_ready || w_abort)) begin
                w_ready[i] = 1'b1;
            end else begin
                w_ready[i] = 1'b0;
            end
        end
    end

    // Serial-side port and shared read data; everything reads zero in IDLE.
    always_comb begin
        m_valid   = 1'b0;
        m_wstrb   = 4'h0;
        m_addr    = 32'h0000_0000;
        m_wdata   = 32'h0000_0000;
        req_rdata = 32'h0000_0000;
        if (w_busy) begin
            m_valid = w_grant_valid && !w_to_hit;
            m_wstrb = w_wstrb_a[r_grant];
            m_addr  = w_addr_a[r_grant];
            m_wdata = w_wdata_a[r_grant];
        end else begin
            m_valid = 1'b0;
        end
        if (|w_ready) begin
            req_rdata = w_abort ? ARB_ABORT_RDATA : m_rdata;
        end else begin
            req_rdata = 32'h0000_0000;
        end
    end

    assign req_ready   = w_ready;
    assign timeout_err = w_abort;

endmodule : serial_bus_arbiter

// File: tb/tb_serial_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_serial_bus_arbiter
// Directed bench for serial_bus_arbiter (NUM_REQ=2, TIMEOUT_CYCLES=8) with a
// small zero-wait-state Serial responder. Honours SERIAL_ARB_TIMEOUT_EN.
// ---------------------------------------------------------------------------
module tb_serial_bus_arbiter;
    import serial_arb_pkg::*;

    localparam int NREQ = 2;

    logic               clk;
    logic               resetn;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [4*NREQ-1:0]  req_wstrb;
    logic [32*NREQ-1:0] req_addr;
    logic [32*NREQ-1:0] req_wdata;
    logic [31:0]        req_rdata;
    logic               m_valid;
    logic [3:0]         m_wstrb;
    logic [31:0]        m_addr;
    logic [31:0]        m_wdata;
    logic               m_ready;
    logic [31:0]        m_rdata;
    logic               timeout_err;

    logic               tx_busy;
    logic               stall_all;
    logic [31:0]        div_val;
    localparam logic [31:0] RX_VAL = 32'h0000_005A;

    int n_checks;
    int n_fail;

    serial_bus_arbiter #(
        .NUM_REQ        (NREQ),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_wstrb   (req_wstrb),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_rdata   (req_rdata),
        .m_valid     (m_valid),
        .m_wstrb     (m_wstrb),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_ready     (m_ready),
        .m_rdata     (m_rdata),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serial responder: zero wait states, except a TX write while tx_busy.
    always_comb begin
        m_ready = 1'b0;
        m_rdata = 32'h0000_0000;
        if (m_valid && !stall_all) begin
            if (m_wstrb != 4'h0 && m_addr == SERIAL_DAT_OFFSET && tx_busy) begin
                m_ready = 1'b0;
            end else begin
                m_ready = 1'b1;
            end
            if (m_wstrb == 4'h0 && m_addr == SERIAL_DIV_OFFSET) begin
                m_rdata = div_val;
            end else if (m_wstrb == 4'h0 && m_addr == SERIAL_DAT_OFFSET) begin
                m_rdata = RX_VAL;
            end else begin
                m_rdata = 32'h0000_0000;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] ws, input logic [31:0] a, input logic [31:0] d);
        req_wstrb[4*i +: 4]  = ws;
        req_addr[32*i +: 32] = a;
        req_wdata[32*i +: 32] = d;
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        req_valid = '0;
        tx_busy   = 1'b0;
        stall_all = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    logic [1:0]  exp_rdy   [8] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    logic [31:0] exp_rdata [8] = '{32'h0, 32'h1, 32'h0, 32'h5A, 32'h0, 32'h1, 32'h0, 32'h5A};

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        resetn    = 1'b1;
        req_valid = '0;
        req_wstrb = '0;
        req_addr  = '0;
        req_wdata = '0;
        tx_busy   = 1'b0;
        stall_all = 1'b0;
        div_val   = 32'h0000_0001;
        #2;
        resetn = 1'b0;
        #1;
        check_eq("rst_m_valid", 32'(m_valid), 32'h0);
        check_eq("rst_req_ready", 32'(req_ready), 32'h0);
        check_eq("rst_req_rdata", req_rdata, 32'h0);
        check_eq("rst_timeout_err", 32'(timeout_err), 32'h0);
        check_eq("rst_m_addr", m_addr, 32'h0);
        do_reset();

        // Single read of the divider by requester 0.
        tick();
        set_req(0, 4'h0, SERIAL_DIV_OFFSET, 32'h0);
        req_valid = 2'b01;
        #1;
        check_eq("t1_idle_m_valid", 32'(m_valid), 32'h0);
        tick();
        check_eq("t1_m_valid", 32'(m_valid), 32'h1);
        check_eq("t1_m_addr", m_addr, 32'h0);
        check_eq("t1_req_ready", 32'(req_ready), 32'h1);
        check_eq("t1_req_rdata", req_rdata, 32'h1);
        tick();
        req_valid = 2'b00;
        #1;
        check_eq("t1_done_m_valid", 32'(m_valid), 32'h0);
        check_eq("t1_done_req_ready", 32'(req_ready), 32'h0);

        // Both requesters hammering: strict 0,1,0,1 rotation.
        do_reset();
        set_req(0, 4'h0, SERIAL_DIV_OFFSET, 32'h0);
        set_req(1, 4'h0, SERIAL_DAT_OFFSET, 32'h0);
        tick();
        req_valid = 2'b11;
        for (int c = 0; c < 8; c++) begin
            #1;
            check_eq($sformatf("t2_ready_c%0d", c), 32'(req_ready), 32'(exp_rdy[c]));
            check_eq($sformatf("t2_rdata_c%0d", c), req_rdata, exp_rdata[c]);
            tick();
        end
        req_valid = 2'b00;

        // TX stall on requester 1 holds the grant; requester 0 waits.
        do_reset();
        div_val = 32'd217;
        set_req(1, 4'hF, SERIAL_DAT_OFFSET, 32'h41);
        set_req(0, 4'h0, SERIAL_DIV_OFFSET, 32'h0);
        tx_busy = 1'b1;
        tick();
        req_valid = 2'b10;
        #1;
        check_eq("t3_idle_m_valid", 32'(m_valid), 32'h0);
        tick();
        req_valid = 2'b11;
        #1;
        check_eq("t3_m_valid", 32'(m_valid), 32'h1);
        check_eq("t3_m_addr", m_addr, 32'h4);
        check_eq("t3_m_wdata", m_wdata, 32'h41);
        check_eq("t3_m_wstrb", 32'(m_wstrb), 32'hF);
        check_eq("t3_stall_ready", 32'(req_ready), 32'h0);
        for (int s = 0; s < 3; s++) begin
            tick();
            check_eq($sformatf("t3_hold_addr_%0d", s), m_addr, 32'h4);
            check_eq($sformatf("t3_hold_ready_%0d", s), 32'(req_ready), 32'h0);
        end
        tick();
        tx_busy = 1'b0;
        #1;
        check_eq("t3_tx_ready", 32'(req_ready), 32'h2);
        check_eq("t3_tx_addr", m_addr, 32'h4);
        tick();
        req_valid = 2'b01;
        #1;
        check_eq("t3_gap_m_valid", 32'(m_valid), 32'h0);
        tick();
        check_eq("t3_r0_addr", m_addr, 32'h0);
        check_eq("t3_r0_ready", 32'(req_ready), 32'h1);
        check_eq("t3_r0_rdata", req_rdata, 32'd217);
        tick();
        req_valid = 2'b00;

        // Serial never answers.
        do_reset();
        div_val = 32'h0000_0001;
        set_req(0, 4'h0, SERIAL_DIV_OFFSET, 32'h0);
        stall_all = 1'b1;
        tick();
        req_valid = 2'b01;
        #1;
        check_eq("t4_idle_err", 32'(timeout_err), 32'h0);
`ifdef SERIAL_ARB_TIMEOUT_EN
        for (int b = 1; b <= 8; b++) begin
            tick();
            if (b < 8) begin
                check_eq($sformatf("t4_wait_ready_%0d", b), 32'(req_ready), 32'h0);
                check_eq($sformatf("t4_wait_err_%0d", b), 32'(timeout_err), 32'h0);
            end else begin
                check_eq("t4_abort_ready", 32'(req_ready), 32'h1);
                check_eq("t4_abort_rdata", req_rdata, 32'hFFFF_FFFF);
                check_eq("t4_abort_err", 32'(timeout_err), 32'h1);
                check_eq("t4_abort_m_valid", 32'(m_valid), 32'h0);
            end
        end
        tick();
        req_valid = 2'b00;
        stall_all = 1'b0;
        #1;
        check_eq("t4_after_err", 32'(timeout_err), 32'h0);
        check_eq("t4_after_m_valid", 32'(m_valid), 32'h0);
`else
        for (int b = 1; b <= 12; b++) begin
            tick();
            check_eq($sformatf("t4_hold_m_valid_%0d", b), 32'(m_valid), 32'h1);
            check_eq($sformatf("t4_hold_ready_%0d", b), 32'(req_ready | 2'(timeout_err)), 32'h0);
        end
        stall_all = 1'b0;
        #1;
        check_eq("t4_late_ready", 32'(req_ready), 32'h1);
        check_eq("t4_late_rdata", req_rdata, 32'h1);
        tick();
        req_valid = 2'b00;
`endif

        // Reset in the middle of a requester-1 transaction.
        do_reset();
        set_req(1, 4'h0, SERIAL_DAT_OFFSET, 32'h0);
        set_req(0, 4'h0, SERIAL_DIV_OFFSET, 32'h0);
        stall_all = 1'b1;
        tick();
        req_valid = 2'b10;
        tick();
        check_eq("t5_busy_m_valid", 32'(m_valid), 32'h1);
        check_eq("t5_busy_m_addr", m_addr, 32'h4);
        #1;
        resetn    = 1'b0;
        req_valid = 2'b11;
        #1;
        check_eq("t5_async_m_valid", 32'(m_valid), 32'h0);
        check_eq("t5_async_ready", 32'(req_ready), 32'h0);
        @(posedge clk);
        @(negedge clk);
        resetn    = 1'b1;
        stall_all = 1'b0;
        tick();
        check_eq("t5_first_ready", 32'(req_ready), 32'h1);
        check_eq("t5_first_addr", m_addr, 32'h0);
        tick();
        req_valid = 2'b00;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_serial_bus_arbiter

// File: doc/serial_bus_arbiter.md
# serial_bus_arbiter

Round-robin arbiter that lets up to four native-bus requesters share one `Serial` peripheral port (divider register at offset 0x0, data register at offset 0x4). It sits between the requesters (CPU core, debug monitor, log DMA) and the `Serial` instance's `valid/ready/wstrb/addr/wdata/rdata` port. It holds a grant for one full transaction, so a stalled TX write (`ready` low while the UART shifts) never interleaves with another requester's access.

## Interface
- `NUM_REQ`, default 2: number of requesters, legal range 2..4.
- `TIMEOUT_CYCLES`, default 1_000_000: abort limit in cycles. Used only when `SERIAL_ARB_TIMEOUT_EN` is defined.

- `clk` in 1: single clock; all state changes on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: per-requester transaction request.
- `req_ready` out NUM_REQ: per-requester completion strobe.
- `req_wstrb` in 4*NUM_REQ: byte strobes; all zero means a read. Requester i occupies bits [4i+3:4i].
- `req_addr` in 32*NUM_REQ: requester addresses.
- `req_wdata` in 32*NUM_REQ: requester write data.
- `req_rdata` out 32: read data, shared by all requesters and qualified by that requester's `req_ready`.
- `m_valid`, `m_wstrb`[4], `m_addr`[32], `m_wdata`[32] out: port driven into `Serial`.
- `m_ready` in 1, `m_rdata` in 32: `Serial` response.
- `timeout_err` out 1: one-cycle pulse when a transaction is aborted.

## Operation
- FSM has two states, IDLE and BUSY.
- **IDLE**
  - If any `req_valid` is set, pick the first set bit searching upward from `last_grant+1`, wrapping modulo NUM_REQ.
  - Register the pick into `grant` and `last_grant`, then go to BUSY.
  - If no request is set, stay in IDLE. `m_valid`=0.
- **BUSY**
  - Mux the granted requester's wstrb/addr/wdata onto `m_*`.
  - `m_valid` = `req_valid[grant]`.
  - `req_ready[grant]` = `m_ready`. All other `req_ready` bits are 0.
  - `req_rdata` = `m_rdata` whenever any `req_ready` bit is set, else 0.
  - When `m_ready`=1, return to IDLE.
  - If the requester drops `req_valid[grant]` before `m_ready` (protocol violation), return to IDLE without a response. `last_grant` keeps the dropped index.
- Reset values:
  - `grant`=0; `last_grant`=NUM_REQ-1, so requester 0 wins the first arbitration.
  - State IDLE; timeout counter 0.
  - All outputs 0.
- Requesters with index >= NUM_REQ do not exist. The picker only searches [0, NUM_REQ-1].

## Timing
- Arbitration latency is 1 cycle. `req_valid` seen in IDLE at edge N gives `m_valid` high from cycle N+1.
- `m_ready` and `m_rdata` are forwarded combinationally to `req_ready` and `req_rdata` in the same cycle.
- Because `Serial` answers register accesses in zero wait states, a transaction completes in 2 cycles: one IDLE cycle, one BUSY cycle.
- A TX write while the UART is shifting holds BUSY until `Serial` raises ready, which can take many cycles. The grant is held throughout.
- Maximum throughput is one transaction every 2 cycles. There is no same-cycle re-grant on completion.
- If all requesters hold `req_valid` continuously, each is served once per NUM_REQ transactions (strict rotation).
- `resetn` falling mid-BUSY forces `m_valid` and `req_ready` low immediately (asynchronous). No completion is signalled.

## Configuration
- `SERIAL_ARB_TIMEOUT_EN` defined:
  - A 32-bit counter clears on entry to BUSY and increments each BUSY cycle without `m_ready`.
  - When the counter equals TIMEOUT_CYCLES-1 and `m_ready`=0, that cycle performs an abort:
    - `m_valid`=0;
    - `req_ready[grant]`=1;
    - `req_rdata`=32'hFFFF_FFFF;
    - `timeout_err`=1;
    - next state IDLE.
  - If `m_ready` arrives on that same cycle, it wins: normal completion, no error.
- `SERIAL_ARB_TIMEOUT_EN` undefined: no counter is built, `timeout_err` is tied to 0, and BUSY waits indefinitely.

## Structure
- Package `serial_arb_pkg` holds:
  - `arb_state_t` enum {IDLE, BUSY};
  - `SERIAL_DIV_OFFSET`=32'h0 and `SERIAL_DAT_OFFSET`=32'h4;
  - `ARB_MAX_REQ`=4;
  - the abort pattern `ARB_ABORT_RDATA`=32'hFFFF_FFFF.
- Sub-module `rr_pick` is a combinational round-robin picker. Inputs: request vector and `last_grant`. Outputs: a `found` flag and the winning index.

## Test plan
- **Single read.** Reset, then req0 reads addr 0x0 with the divider at 1. Expect `m_valid` at cycle 1, `req_ready[0]` in the same cycle, and `req_rdata`=32'h1.
- **Simultaneous requests.** req0 and req1 both valid from reset, each doing repeated reads. Expect grants in order 0,1,0,1, and `req_ready` never high for two requesters in one cycle.
- **Held grant during TX stall.** req1 writes 0x41 to 0x4 with the UART busy, while req0 reads 0x0 concurrently. Expect `m_addr` to stay 0x4 until `Serial` ready. req0 is granted only afterwards, and the divider read returns the correct value.
- **Timeout abort.** With `SERIAL_ARB_TIMEOUT_EN`, TIMEOUT_CYCLES=8, and `m_ready` tied 0: req0 gets `req_ready`, `req_rdata`=32'hFFFF_FFFF, and a one-cycle `timeout_err` on its 8th BUSY cycle.
- **Reset mid-transaction.** Assert `resetn`=0 mid-BUSY. Expect `m_valid`=0 asynchronously. After release, req0 wins first even if req1 was granted before reset.
